// File: rtl/bias_accum_sequencer_pkg.sv
// Shared types and constants for the bias accumulate/saturate sequencer.
package bias_seq_pkg;

  localparam int DEF_DW = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_BIAS  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [DEF_DW-1:0] SAT_MAX = {1'b0, {(DEF_DW-1){1'b1}}};
  localparam logic [DEF_DW-1:0] SAT_MIN = {1'b1, {(DEF_DW-1){1'b0}}};

  // Accumulator width: room for N_PASS inputs plus one bias word without overflow.
  function automatic int acc_w(input int dw, input int n_pass);
    return dw + $clog2(n_pass + 1) + 1;
  endfunction

endpackage

// File: rtl/bias_accum_sequencer_if.sv
// Start/stream/bias-bank/status bundle between the adder trees, bias banks and next-layer buffer.
interface bias_accum_sequencer_if #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int N_GROUPS     = 4
);
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_adder_tree*DW-1:0] in_data;
  logic [GW-1:0]              bias_sel;
  logic [N_adder_tree*DW-1:0] bias_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [N_adder_tree*DW-1:0] out_data;
  logic [GW-1:0]              out_group;
  logic                       busy;
  logic                       done;

  modport master (
    output start, in_valid, in_data, bias_data, out_ready,
    input  in_ready, bias_sel, out_valid, out_data, out_group, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, bias_data, out_ready,
    output in_ready, bias_sel, out_valid, out_data, out_group, busy, done
  );

endinterface

// File: rtl/bias_accum_sequencer_sat_lane.sv
// One lane: sign-extended partial-sum accumulation, bias add and saturation to DW bits.
module bias_sat_lane #(
  parameter int DW    = 18,
  parameter int ACC_W = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_clr,
  input  logic          acc_en,
  input  logic          bias_en,
  input  logic [DW-1:0] in_lane,
  input  logic [DW-1:0] bias_lane,
  output logic [DW-1:0] out_lane
);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] in_ext_s;
  logic signed [ACC_W-1:0] bias_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic [DW-1:0]           sat_s;
  logic [DW-1:0]           out_r;

  assign in_ext_s   = {{(ACC_W-DW){in_lane[DW-1]}}, in_lane};
  assign bias_ext_s = {{(ACC_W-DW){bias_lane[DW-1]}}, bias_lane};
  assign out_lane   = out_r;

  // Bias add and clamp to the signed DW range.
  always_comb begin
    sum_s = acc_r + bias_ext_s;
    sat_s = sum_s[DW-1:0];
    if (sum_s > SAT_HI) begin
      sat_s = {1'b0, {(DW-1){1'b1}}};
    end else if (sum_s < SAT_LO) begin
      sat_s = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_s = sum_s[DW-1:0];
    end
  end

  // Partial-sum accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (acc_clr) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (acc_en) begin
      acc_r <= acc_r + in_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Result register, loaded once per group and held through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= {DW{1'b0}};
    end else if (bias_en) begin
      out_r <= sat_s;
    end else begin
      out_r <= out_r;
    end
  end

endmodule

// File: rtl/bias_accum_sequencer.sv
// Per-layer bias sequencer: accumulates N_PASS vectors per group, adds the group's bias bank, saturates.
module bias_accum_sequencer
  import bias_seq_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int N_GROUPS     = 4,
  parameter int N_PASS       = 3
) (
  input logic              clk,
  input logic              rst_n,
  bias_accum_sequencer_if.slave bus
);

  localparam int ACC_W = acc_w(DW, N_PASS);
  localparam int GW    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int PW    = (N_PASS > 1) ? $clog2(N_PASS) : 1;
  localparam logic [PW-1:0] LAST_PASS  = PW'(N_PASS - 1);
  localparam logic [GW-1:0] LAST_GROUP = GW'(N_GROUPS - 1);

  state_e                     state_r;
  state_e                     state_nx;
  logic [PW-1:0]              pass_r;
  logic [GW-1:0]              group_r;
  logic [GW-1:0]              out_group_r;
  logic                       done_r;
  logic                       acc_clr_s;
  logic                       acc_en_s;
  logic                       bias_en_s;
  logic                       pass_clr_s;
  logic                       pass_inc_s;
  logic                       grp_clr_s;
  logic                       grp_inc_s;
  logic                       done_nx_s;
  logic [N_adder_tree*DW-1:0] out_data_s;

  assign bus.in_ready  = (state_r == ST_ACCUM);
  assign bus.out_valid = (state_r == ST_OUT);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.done      = done_r;
  assign bus.bias_sel  = group_r;
  assign bus.out_group = out_group_r;
  assign bus.out_data  = out_data_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state and datapath enables.
  always_comb begin
    state_nx   = state_r;
    acc_clr_s  = 1'b0;
    acc_en_s   = 1'b0;
    bias_en_s  = 1'b0;
    pass_clr_s = 1'b0;
    pass_inc_s = 1'b0;
    grp_clr_s  = 1'b0;
    grp_inc_s  = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx   = ST_ACCUM;
          acc_clr_s  = 1'b1;
          pass_clr_s = 1'b1;
          grp_clr_s  = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_en_s = 1'b1;
          if (pass_r == LAST_PASS) begin
            state_nx   = ST_BIAS;
            pass_clr_s = 1'b1;
          end else begin
            state_nx   = ST_ACCUM;
            pass_inc_s = 1'b1;
          end
        end else begin
          state_nx = ST_ACCUM;
        end
      end
      ST_BIAS: begin
        bias_en_s = 1'b1;
        state_nx  = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          if (group_r == LAST_GROUP) begin
            state_nx  = ST_IDLE;
            grp_clr_s = 1'b1;
            done_nx_s = 1'b1;
          end else begin
            state_nx   = ST_ACCUM;
            grp_inc_s  = 1'b1;
            acc_clr_s  = 1'b1;
            pass_clr_s = 1'b1;
          end
        end else begin
          state_nx = ST_OUT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Pass/group counters, output group tag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_r      <= PW'(0);
      group_r     <= GW'(0);
      out_group_r <= GW'(0);
      done_r      <= 1'b0;
    end else begin
      if (pass_clr_s) begin
        pass_r <= PW'(0);
      end else if (pass_inc_s) begin
        pass_r <= pass_r + PW'(1);
      end else begin
        pass_r <= pass_r;
      end
      if (grp_clr_s) begin
        group_r <= GW'(0);
      end else if (grp_inc_s) begin
        group_r <= group_r + GW'(1);
      end else begin
        group_r <= group_r;
      end
      if (bias_en_s) begin
        out_group_r <= group_r;
      end else begin
        out_group_r <= out_group_r;
      end
      done_r <= done_nx_s;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_sat_lane #(
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_clr   (acc_clr_s),
      .acc_en    (acc_en_s),
      .bias_en   (bias_en_s),
      .in_lane   (bus.in_data[i*DW +: DW]),
      .bias_lane (bus.bias_data[i*DW +: DW]),
      .out_lane  (out_data_s[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_bias_accum_sequencer.sv
// Directed self-checking bench for bias_accum_sequencer.
module tb_bias_accum_sequencer;
  import bias_seq_pkg::*;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int NG = 4;
  localparam int NP = 3;
  localparam int VW = N * DW;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [VW-1:0] bank [NG];

  always #5 clk = ~clk;

  bias_accum_sequencer_if #(.N_adder_tree(N), .DW(DW), .N_GROUPS(NG)) bif ();

  assign bif.bias_data = bank[bif.bias_sel];

  bias_accum_sequencer #(.N_adder_tree(N), .DW(DW), .N_GROUPS(NG), .N_PASS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
    return {N{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.out_ready = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic feed(input logic [VW-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      bif.in_valid = 1'b1;
      bif.in_data = v;
      tick();
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.out_ready = 1'b0;
    for (int g = 0; g < NG; g++) bank[g] = '0;
    tick();
    tick();
    checks++;
    if ({bif.in_ready, bif.out_valid, bif.busy, bif.done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {bif.in_ready, bif.out_valid, bif.busy, bif.done});
    end
    checks++;
    if (bif.out_data !== {VW{1'b0}}) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", bif.out_data);
    end
    checks++;
    if ({bif.out_group, bif.bias_sel} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_group got=%b exp=0000", {bif.out_group, bif.bias_sel});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    apply_reset();
    bank[0] = rep(18'h01D8C);
    bif.out_ready = 1'b1;
    pulse_start();
    checks++;
    if ({bif.in_ready, bif.busy} !== 2'b11) begin
      failures++;
      $display("FAIL basic_accum_state got=%b exp=11", {bif.in_ready, bif.busy});
    end
    feed(rep(18'h00100), 3);
    checks++;
    if ({bif.in_ready, bif.out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL basic_bias_cycle got=%b exp=00", {bif.in_ready, bif.out_valid});
    end
    tick();
    checks++;
    if (bif.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency out_valid got=%b exp=1", bif.out_valid);
    end
    checks++;
    if (bif.out_data !== rep(18'h0208C)) begin
      failures++;
      $display("FAIL basic_data got=%h exp=%h", bif.out_data, rep(18'h0208C));
    end
    checks++;
    if (bif.out_group !== 2'd0) begin
      failures++;
      $display("FAIL basic_group got=%0d exp=0", bif.out_group);
    end
    tick();
    checks++;
    if ({bif.bias_sel, bif.in_ready, bif.out_valid} !== {2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL basic_next_group got=%b exp=0110", {bif.bias_sel, bif.in_ready, bif.out_valid});
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    bank[0] = rep(18'h00100);
    bif.out_ready = 1'b0;
    pulse_start();
    feed(rep(18'h1FFFF), 3);
    tick();
    checks++;
    if (bif.out_data !== rep(SAT_MAX)) begin
      failures++;
      $display("FAIL sat_pos got=%h exp=%h", bif.out_data, rep(SAT_MAX));
    end
    apply_reset();
    bank[0] = rep(18'h3D03C);
    pulse_start();
    feed(rep(18'h20000), 3);
    tick();
    checks++;
    if (bif.out_data !== rep(SAT_MIN)) begin
      failures++;
      $display("FAIL sat_neg got=%h exp=%h", bif.out_data, rep(SAT_MIN));
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bank[0] = rep(18'h00222);
    bank[1] = rep(18'h00011);
    bif.out_ready = 1'b0;
    pulse_start();
    feed(rep(18'h00010), 3);
    tick();
    for (int k = 0; k < 5; k++) begin
      bif.in_valid = k[0];
      bif.in_data = rep(18'h00777);
      checks++;
      if ({bif.out_valid, bif.in_ready, bif.out_group} !== {1'b1, 1'b0, 2'd0}) begin
        failures++;
        $display("FAIL bp_ctrl cyc=%0d got=%b exp=1000", k, {bif.out_valid, bif.in_ready, bif.out_group});
      end
      checks++;
      if (bif.out_data !== rep(18'h00252)) begin
        failures++;
        $display("FAIL bp_data cyc=%0d got=%h exp=%h", k, bif.out_data, rep(18'h00252));
      end
      tick();
    end
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    tick();
    checks++;
    if ({bif.bias_sel, bif.in_ready, bif.out_valid} !== {2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bp_release got=%b exp=0110", {bif.bias_sel, bif.in_ready, bif.out_valid});
    end
    bif.out_ready = 1'b0;
    feed(rep(18'h00005), 3);
    tick();
    checks++;
    if (bif.out_data !== rep(18'h00020) || bif.out_group !== 2'd1) begin
      failures++;
      $display("FAIL bp_group1 got=%h/%0d exp=%h/1", bif.out_data, bif.out_group, rep(18'h00020));
    end
  endtask

  task automatic test_full_run();
    logic [VW-1:0] din;
    logic [VW-1:0] exp_v;
    apply_reset();
    for (int g = 0; g < NG; g++)
      for (int i = 0; i < N; i++)
        bank[g][i*DW +: DW] = DW'(16 * (g + 1) + i);
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'(4 * (i + 1));
    bif.out_ready = 1'b1;
    pulse_start();
    for (int g = 0; g < NG; g++) begin
      checks++;
      if (bif.bias_sel !== 2'(g) || bif.busy !== 1'b1) begin
        failures++;
        $display("FAIL run_bias_sel g=%0d got=%0d busy=%b exp=%0d busy=1", g, bif.bias_sel, bif.busy, g);
      end
      for (int p = 0; p < NP; p++) begin
        bif.in_valid = 1'b1;
        bif.in_data = din;
        bif.start = (g == 1 && p == 1);
        tick();
        bif.start = 1'b0;
      end
      bif.in_valid = 1'b0;
      tick();
      for (int i = 0; i < N; i++) exp_v[i*DW +: DW] = DW'(12 * (i + 1) + 16 * (g + 1) + i);
      checks++;
      if (bif.out_data !== exp_v || bif.out_group !== 2'(g) || bif.done !== 1'b0) begin
        failures++;
        $display("FAIL run_out g=%0d got=%h grp=%0d done=%b exp=%h grp=%0d done=0",
                 g, bif.out_data, bif.out_group, bif.done, exp_v, g);
      end
      tick();
    end
    checks++;
    if ({bif.done, bif.busy, bif.bias_sel} !== {1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL run_done got=%b exp=1000", {bif.done, bif.busy, bif.bias_sel});
    end
    tick();
    checks++;
    if ({bif.done, bif.busy, bif.out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL run_done_pulse got=%b exp=000", {bif.done, bif.busy, bif.out_valid});
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    bank[0] = '0;
    bif.out_ready = 1'b0;
    pulse_start();
    feed(rep(18'h00050), 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.in_ready, bif.out_valid, bif.busy, bif.done, bif.bias_sel, bif.out_group} !== 8'h00
        || bif.out_data !== {VW{1'b0}}) begin
      failures++;
      $display("FAIL midrun_reset got=%b data=%h exp=0",
               {bif.in_ready, bif.out_valid, bif.busy, bif.done, bif.bias_sel, bif.out_group}, bif.out_data);
    end
    #1;
    rst_n = 1'b1;
    tick();
    pulse_start();
    feed(rep(18'h00001), 3);
    tick();
    checks++;
    if (bif.out_data !== rep(18'h00003) || bif.out_group !== 2'd0) begin
      failures++;
      $display("FAIL midrun_restart got=%h/%0d exp=%h/0", bif.out_data, bif.out_group, rep(18'h00003));
    end
  endtask

  task automatic test_stall_toggle();
    apply_reset();
    bank[0] = rep(18'h00002);
    bif.out_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      bif.in_valid = (c % 2 == 0);
      bif.in_data = rep(18'h00007);
      tick();
      if (c == 1 || c == 3) begin
        checks++;
        if (bif.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL toggle_ready c=%0d got=%b exp=1", c, bif.in_ready);
        end
      end
    end
    bif.in_valid = 1'b0;
    checks++;
    if (bif.out_valid !== 1'b1 || bif.out_data !== rep(18'h00017)) begin
      failures++;
      $display("FAIL toggle_result got=%b/%h exp=1/%h", bif.out_valid, bif.out_data, rep(18'h00017));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_full_run();
    test_reset_midrun();
    test_stall_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
